// File: rtl/mem_reader.sv
// Single-request memory read sequencer: IDLE -> ISSUE -> WAIT -> DONE.
// Define MEM_READER_TIMEOUT_EN to abort a read after TIMEOUT WAIT cycles with an err_o pulse.
`timescale 1ns / 1ps

module mem_reader #(
   parameter int unsigned W       = 16,
   parameter int unsigned AW      = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_i,
   input  logic [AW-1:0] addr_i,
   output logic          busy_o,
   output logic [AW-1:0] mem_addr_o,
   output logic          mem_rd_en_o,
   input  logic          mem_ack_i,
   input  logic [W-1:0]  mem_d_i,
   output logic [W-1:0]  d_o,
   output logic          r_o,
   output logic          err_o
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_addr;
   logic [W-1:0]  r_data;
   logic          r_rd_en;
   logic          r_ready;

`ifdef MEM_READER_TIMEOUT_EN
   localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] r_wait_cnt;
   logic            r_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_data     <= '0;
         r_rd_en    <= 1'b0;
         r_ready    <= 1'b0;
`ifdef MEM_READER_TIMEOUT_EN
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
`endif
      end else begin
         // Strobes default low so each one lasts exactly one cycle.
         r_rd_en <= 1'b0;
         r_ready <= 1'b0;
`ifdef MEM_READER_TIMEOUT_EN
         r_err   <= 1'b0;
`endif
         unique case (r_state)
            StIdle: begin
               if (req_i) begin
                  r_addr  <= addr_i;
                  r_rd_en <= 1'b1;
                  r_state <= StIssue;
               end
            end
            StIssue: begin
`ifdef MEM_READER_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
               r_state <= StWait;
            end
            StWait: begin
               // Ack has priority over an expiring timeout on the same edge.
               if (mem_ack_i) begin
                  r_data  <= mem_d_i;
                  r_ready <= 1'b1;
                  r_state <= StDone;
               end
`ifdef MEM_READER_TIMEOUT_EN
               else if (r_wait_cnt == LastCnt) begin
                  r_err   <= 1'b1;
                  r_state <= StIdle;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
`endif
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign busy_o      = (r_state != StIdle);
   assign mem_addr_o  = r_addr;
   assign mem_rd_en_o = r_rd_en;
   assign d_o         = r_data;
   assign r_o         = r_ready;

`ifdef MEM_READER_TIMEOUT_EN
   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: expected strobe addresses and read data are queued at request
// time and retired by a monitor when mem_rd_en_o / r_o appear.
`timescale 1ns / 1ps

module tb_mem_reader;

   localparam int unsigned W          = 16;
   localparam int unsigned AW         = 16;
   localparam int unsigned TB_TIMEOUT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic          busy_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_rd_en_o;
   logic          mem_ack_i = 1'b0;
   logic [W-1:0]  mem_d_i = '0;
   logic [W-1:0]  d_o;
   logic          r_o;
   logic          err_o;

   int vectors = 0;
   int miscompares = 0;
   int n_strobe = 0;
   int n_ready = 0;
   int n_err = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [W-1:0]  exp_data_q[$];
   logic [AW-1:0] mon_addr;
   logic [W-1:0]  mon_data;

   mem_reader #(
      .W      (W),
      .AW     (AW),
      .TIMEOUT(TB_TIMEOUT)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .addr_i     (addr_i),
      .busy_o     (busy_o),
      .mem_addr_o (mem_addr_o),
      .mem_rd_en_o(mem_rd_en_o),
      .mem_ack_i  (mem_ack_i),
      .mem_d_i    (mem_d_i),
      .d_o        (d_o),
      .r_o        (r_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   // Monitor samples mid-cycle and retires scoreboard entries.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_rd_en_o) begin
            n_strobe++;
            vectors++;
            if (exp_addr_q.size() == 0) begin
               miscompares++;
               $display("FAIL strobe: unexpected mem_rd_en_o at addr %h, want no strobe", mem_addr_o);
            end else begin
               mon_addr = exp_addr_q.pop_front();
               if (mem_addr_o !== mon_addr) begin
                  miscompares++;
                  $display("FAIL strobe_addr: got %h want %h", mem_addr_o, mon_addr);
               end
            end
         end
         if (r_o) begin
            n_ready++;
            vectors++;
            if (exp_data_q.size() == 0) begin
               miscompares++;
               $display("FAIL ready: unexpected r_o with d_o %h, want no r_o", d_o);
            end else begin
               mon_data = exp_data_q.pop_front();
               if (d_o !== mon_data) begin
                  miscompares++;
                  $display("FAIL read_data: got %h want %h", d_o, mon_data);
               end
            end
         end
         if (err_o) n_err++;
         vectors++;
         if ((r_o & err_o) !== 1'b0) begin
            miscompares++;
            $display("FAIL r_err_excl: got r_o=%b err_o=%b, want not both high", r_o, err_o);
         end
      end
   end

   // Stimulus only: one read with ack after dly WAIT cycles; the monitor checks results.
   task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] d, input int dly);
      req_i  = 1'b1;
      addr_i = a;
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
      @(posedge clk); #1;
      req_i  = 1'b0;
      addr_i = 16'($urandom);
      @(posedge clk); #1;
      repeat (dly) begin
         @(posedge clk); #1;
      end
      mem_ack_i = 1'b1;
      mem_d_i   = d;
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      mem_d_i   = 16'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if ({busy_o, mem_addr_o, mem_rd_en_o, d_o, r_o, err_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b addr=%h rd=%b d=%h r=%b err=%b, want all 0",
                  busy_o, mem_addr_o, mem_rd_en_o, d_o, r_o, err_o);
      end
      req_i     = 1'b1;
      mem_ack_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy_o, mem_rd_en_o, r_o} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_held: got busy=%b rd=%b r=%b, want 000", busy_o, mem_rd_en_o, r_o);
      end
      req_i     = 1'b0;
      mem_ack_i = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic test_basic;
      int s0;
      int r0;
      s0 = n_strobe;
      r0 = n_ready;
      req_i  = 1'b1;
      addr_i = 16'h3000;
      exp_addr_q.push_back(16'h3000);
      exp_data_q.push_back(16'hBEEF);
      @(posedge clk); #1;  // edge k: first edge after reset release
      req_i  = 1'b0;
      vectors++;
      if ({busy_o, mem_rd_en_o, r_o} !== 3'b110 || mem_addr_o !== 16'h3000) begin
         miscompares++;
         $display("FAIL basic_issue: got busy=%b rd=%b r=%b addr=%h, want 110 addr 3000",
                  busy_o, mem_rd_en_o, r_o, mem_addr_o);
      end
      @(posedge clk); #1;  // edge k+1: WAIT
      vectors++;
      if ({busy_o, mem_rd_en_o, r_o} !== 3'b100) begin
         miscompares++;
         $display("FAIL basic_wait: got busy=%b rd=%b r=%b, want 100", busy_o, mem_rd_en_o, r_o);
      end
      mem_ack_i = 1'b1;
      mem_d_i   = 16'hBEEF;
      @(posedge clk); #1;  // edge k+2: ack captured
      mem_ack_i = 1'b0;
      mem_d_i   = 16'h0000;
      vectors++;
      if (r_o !== 1'b1 || d_o !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL basic_done: got r=%b d=%h, want r=1 d=beef", r_o, d_o);
      end
      @(posedge clk); #1;
      vectors++;
      if ({busy_o, r_o} !== 2'b00 || d_o !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL basic_idle: got busy=%b r=%b d=%h, want 00 d=beef", busy_o, r_o, d_o);
      end
      vectors++;
      if ((n_strobe - s0) !== 1 || (n_ready - r0) !== 1) begin
         miscompares++;
         $display("FAIL basic_counts: got strobes=%0d readies=%0d, want 1 1",
                  n_strobe - s0, n_ready - r0);
      end
   endtask

   task automatic test_req_during_wait;
      int s0;
      s0 = n_strobe;
      req_i  = 1'b1;
      addr_i = 16'h3000;
      exp_addr_q.push_back(16'h3000);
      exp_data_q.push_back(16'hA5A5);
      @(posedge clk); #1;
      req_i = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         req_i  = ~req_i;
         addr_i = 16'h4000;
         @(posedge clk); #1;
      end
      req_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b1 || mem_addr_o !== 16'h3000) begin
         miscompares++;
         $display("FAIL rdw_hold: got busy=%b addr=%h, want 1 3000", busy_o, mem_addr_o);
      end
      mem_ack_i = 1'b1;
      mem_d_i   = 16'hA5A5;
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (mem_addr_o !== 16'h3000 || (n_strobe - s0) !== 1 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rdw_single: got addr=%h strobes=%0d busy=%b, want 3000 1 0",
                  mem_addr_o, n_strobe - s0, busy_o);
      end
   endtask

   task automatic test_ack_idle;
      int r0;
      r0 = n_ready;
      mem_ack_i = 1'b1;
      mem_d_i   = 16'hFFFF;
      repeat (3) begin
         @(posedge clk); #1;
      end
      mem_ack_i = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (d_o !== 16'hA5A5 || (n_ready - r0) !== 0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_idle: got d=%h readies=%0d busy=%b, want a5a5 0 0",
                  d_o, n_ready - r0, busy_o);
      end
   endtask

   task automatic test_back_to_back;
      int s0;
      int r0;
      logic [W-1:0] last;
      s0 = n_strobe;
      r0 = n_ready;
      last = '0;
      for (int i = 0; i < 4; i++) begin
         last = 16'($urandom);
         do_read(16'($urandom), last, i);
      end
      vectors++;
      if ((n_strobe - s0) !== 4 || (n_ready - r0) !== 4 || d_o !== last) begin
         miscompares++;
         $display("FAIL b2b: got strobes=%0d readies=%0d d=%h, want 4 4 %h",
                  n_strobe - s0, n_ready - r0, d_o, last);
      end
   endtask

   task automatic test_wait_delay;
      int r0;
      int dly;
      r0 = n_ready;
`ifdef MEM_READER_TIMEOUT_EN
      dly = 2;
`else
      dly = 5;
`endif
      req_i  = 1'b1;
      addr_i = 16'h2222;
      exp_addr_q.push_back(16'h2222);
      exp_data_q.push_back(16'h1234);
      @(posedge clk); #1;
      req_i     = 1'b0;
      mem_ack_i = 1'b1;  // ack during ISSUE must be ignored
      mem_d_i   = 16'hDEAD;
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      for (int i = 0; i < dly; i++) begin
         vectors++;
         if (busy_o !== 1'b1 || r_o !== 1'b0) begin
            miscompares++;
            $display("FAIL delay_busy: cycle %0d got busy=%b r=%b, want 1 0", i, busy_o, r_o);
         end
         @(posedge clk); #1;
      end
      mem_ack_i = 1'b1;
      mem_d_i   = 16'h1234;
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b1 || r_o !== 1'b1) begin
         miscompares++;
         $display("FAIL delay_done: got busy=%b r=%b, want 1 1", busy_o, r_o);
      end
      @(posedge clk); #1;
      vectors++;
      if (d_o !== 16'h1234 || (n_ready - r0) !== 1) begin
         miscompares++;
         $display("FAIL delay_data: got d=%h readies=%0d, want 1234 1", d_o, n_ready - r0);
      end
   endtask

`ifdef MEM_READER_TIMEOUT_EN
   task automatic test_timeout;
      int e0;
      int r0;
      e0 = n_err;
      r0 = n_ready;
      req_i  = 1'b1;
      addr_i = 16'h5000;
      exp_addr_q.push_back(16'h5000);
      @(posedge clk); #1;
      req_i = 1'b0;
      @(posedge clk); #1;  // first WAIT cycle
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_wait: cycle %0d got busy=%b err=%b, want 1 0", i, busy_o, err_o);
         end
      end
      @(posedge clk); #1;  // after 3 WAIT cycles
      vectors++;
      if ({err_o, busy_o, r_o} !== 3'b100 || d_o !== 16'h1234) begin
         miscompares++;
         $display("FAIL to_err: got err=%b busy=%b r=%b d=%h, want 100 d=1234",
                  err_o, busy_o, r_o, d_o);
      end
      @(posedge clk); #1;
      vectors++;
      if (err_o !== 1'b0 || (n_err - e0) !== 1 || (n_ready - r0) !== 0) begin
         miscompares++;
         $display("FAIL to_pulse: got err=%b errs=%0d readies=%0d, want 0 1 0",
                  err_o, n_err - e0, n_ready - r0);
      end
      // Ack on the expiry edge must complete normally.
      do_read(16'h5100, 16'h0F0F, TB_TIMEOUT - 1);
      vectors++;
      if (d_o !== 16'h0F0F || (n_err - e0) !== 1 || (n_ready - r0) !== 1) begin
         miscompares++;
         $display("FAIL to_ack_wins: got d=%h errs=%0d readies=%0d, want 0f0f 1 1",
                  d_o, n_err - e0, n_ready - r0);
      end
   endtask
`endif

   task automatic test_reset_mid;
      int r0;
      r0 = n_ready;
      req_i  = 1'b1;
      addr_i = 16'h6000;
      exp_addr_q.push_back(16'h6000);
      @(posedge clk); #1;
      req_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;  // in WAIT
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy_o, mem_addr_o, mem_rd_en_o, d_o, r_o, err_o} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid: got busy=%b addr=%h rd=%b d=%h r=%b err=%b, want all 0",
                  busy_o, mem_addr_o, mem_rd_en_o, d_o, r_o, err_o);
      end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      mem_ack_i = 1'b1;
      mem_d_i   = 16'h7777;
      repeat (2) begin
         @(posedge clk); #1;
      end
      mem_ack_i = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (d_o !== 16'h0000 || busy_o !== 1'b0 || (n_ready - r0) !== 0) begin
         miscompares++;
         $display("FAIL rst_late_ack: got d=%h busy=%b readies=%0d, want 0000 0 0",
                  d_o, busy_o, n_ready - r0);
      end
      do_read(16'h6100, 16'h5A5A, 0);
      vectors++;
      if (d_o !== 16'h5A5A) begin
         miscompares++;
         $display("FAIL rst_recover: got d=%h want 5a5a", d_o);
      end
   endtask

   initial begin
      int exp_err;
      test_reset();
      test_basic();
      test_req_during_wait();
      test_ack_idle();
      test_back_to_back();
      test_wait_delay();
`ifdef MEM_READER_TIMEOUT_EN
      test_timeout();
      exp_err = 1;
`else
      exp_err = 0;
`endif
      test_reset_mid();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (exp_addr_q.size() != 0 || exp_data_q.size() != 0 || n_err != exp_err) begin
         miscompares++;
         $display("FAIL drain: got pending addr=%0d data=%0d errs=%0d, want 0 0 %0d",
                  exp_addr_q.size(), exp_data_q.size(), n_err, exp_err);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
